// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared ALU codes, opcodes, functs and FSM encodings
package multicycle_ctrl_pkg;

    localparam int ALU_CONTROL_LENGTH = 4;
    typedef logic [ALU_CONTROL_LENGTH-1:0] alu_cont_t;

    localparam alu_cont_t ALU_CONTROL_NOP  = 4'd0;
    localparam alu_cont_t ALU_CONTROL_ADD  = 4'd1;
    localparam alu_cont_t ALU_CONTROL_ADDU = 4'd2;
    localparam alu_cont_t ALU_CONTROL_SUBU = 4'd3;
    localparam alu_cont_t ALU_CONTROL_ORI  = 4'd4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;

    typedef enum logic [3:0] {
        S_RST,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC_R,
        S_ALUWB_R,
        S_EXEC_I,
        S_ALUWB_I,
        S_BRANCH,
        S_JUMP,
        S_ERR
    } state_t;

    // What the ALU is being used for in the current state.
    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_ADDR,
        CLS_RTYPE,
        CLS_ORI,
        CLS_SUB
    } alu_cls_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - controller <-> datapath/memory signal bundle
interface multicycle_ctrl_if;
    import multicycle_ctrl_pkg::*;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_rd;
    logic       mem_wr;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    alu_cont_t  alu_cont;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       err;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_rd, mem_wr, iord, ir_write, pc_en, pc_src, alu_src_a,
               alu_src_b, ext_zero, alu_cont, reg_dst, mem_to_reg, reg_write, err
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_rd, mem_wr, iord, ir_write, pc_en, pc_src, alu_src_a,
               alu_src_b, ext_zero, alu_cont, reg_dst, mem_to_reg, reg_write, err
    );

endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// rtl/multicycle_ctrl_alu_decoder.sv - ALU op select and illegal-instruction detect
module multicycle_ctrl_alu_decoder
    import multicycle_ctrl_pkg::*;
(
    input  alu_cls_t   i_cls,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output alu_cont_t  o_alu_cont,
    output logic       o_illegal
);

    // ALU operation for the current state class; R-type picks by funct
    always_comb begin
        o_alu_cont = ALU_CONTROL_NOP;
        case (i_cls)
            CLS_ADDR: o_alu_cont = ALU_CONTROL_ADDU;
            CLS_SUB:  o_alu_cont = ALU_CONTROL_SUBU;
            CLS_ORI:  o_alu_cont = ALU_CONTROL_ORI;
            CLS_RTYPE: begin
                case (i_funct)
                    FN_ADD:  o_alu_cont = ALU_CONTROL_ADD;
                    FN_ADDU: o_alu_cont = ALU_CONTROL_ADDU;
                    FN_SUBU: o_alu_cont = ALU_CONTROL_SUBU;
                    default: o_alu_cont = ALU_CONTROL_NOP;
                endcase
            end
            default: o_alu_cont = ALU_CONTROL_NOP;
        endcase
    end

    // Anything outside the supported opcode/funct set is illegal
    always_comb begin
        o_illegal = 1'b1;
        case (i_opcode)
            OP_RTYPE: o_illegal = !((i_funct == FN_ADD) || (i_funct == FN_ADDU) ||
                                    (i_funct == FN_SUBU));
            OP_LW, OP_SW, OP_ORI, OP_BEQ, OP_J: o_illegal = 1'b0;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS-lite main controller with memory wait/timeout
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_wait_cnt;
    logic        w_wait_state;
    logic        w_timeout;
    logic        w_stay;
    alu_cls_t    w_cls;
    alu_cont_t   w_alu_cont;
    logic        w_illegal;

    multicycle_ctrl_alu_decoder u_alu_decoder (
        .i_cls      (w_cls),
        .i_opcode   (bus.opcode),
        .i_funct    (bus.funct),
        .o_alu_cont (w_alu_cont),
        .o_illegal  (w_illegal)
    );

    // A wait state times out on its MEM_TIMEOUT-th cycle without mem_ready
    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_timeout    = w_wait_state && !bus.mem_ready && (r_wait_cnt == TIMEOUT_LAST);
    assign w_stay       = w_wait_state && !bus.mem_ready && !w_timeout;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_next;
        end
    end

    // Wait counter: counts while a request is stalled, zero on every other path
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (w_stay) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST:    w_next = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ready)  w_next = S_DECODE;
                else if (w_timeout) w_next = S_ERR;
            end
            S_DECODE: begin
                if (w_illegal) begin
                    w_next = S_ERR;
                end else begin
                    case (bus.opcode)
                        OP_LW, OP_SW: w_next = S_MEMADR;
                        OP_RTYPE:     w_next = S_EXEC_R;
                        OP_ORI:       w_next = S_EXEC_I;
                        OP_BEQ:       w_next = S_BRANCH;
                        OP_J:         w_next = S_JUMP;
                        default:      w_next = S_ERR;
                    endcase
                end
            end
            S_MEMADR: w_next = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (bus.mem_ready)  w_next = S_MEMWB;
                else if (w_timeout) w_next = S_ERR;
            end
            S_MEMWR: begin
                if (bus.mem_ready)  w_next = S_FETCH;
                else if (w_timeout) w_next = S_ERR;
            end
            S_EXEC_R:  w_next = S_ALUWB_R;
            S_EXEC_I:  w_next = S_ALUWB_I;
            S_MEMWB, S_ALUWB_R, S_ALUWB_I, S_BRANCH, S_JUMP: w_next = S_FETCH;
            S_ERR:     w_next = S_ERR;
            default:   w_next = S_ERR;
        endcase
    end

    // Output decode; architectural writes are suppressed while rst_n is low
    always_comb begin
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.iord       = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_en      = 1'b0;
        bus.pc_src     = 2'd0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'd0;
        bus.ext_zero   = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        bus.err        = 1'b0;
        w_cls          = CLS_NONE;
        case (r_state)
            S_FETCH: begin
                bus.mem_rd    = 1'b1;
                bus.alu_src_b = 2'd1;
                w_cls         = CLS_ADDR;
                bus.ir_write  = bus.mem_ready && rst_n;
                bus.pc_en     = bus.mem_ready && rst_n;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'd3;
                w_cls         = CLS_ADDR;
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
                w_cls         = CLS_ADDR;
            end
            S_MEMRD: begin
                bus.mem_rd = 1'b1;
                bus.iord   = 1'b1;
            end
            S_MEMWB: begin
                bus.reg_write  = rst_n;
                bus.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                bus.mem_wr = 1'b1;
                bus.iord   = 1'b1;
            end
            S_EXEC_R: begin
                bus.alu_src_a = 1'b1;
                w_cls         = CLS_RTYPE;
            end
            S_ALUWB_R: begin
                bus.reg_write = rst_n;
                bus.reg_dst   = 1'b1;
            end
            S_EXEC_I: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
                bus.ext_zero  = 1'b1;
                w_cls         = CLS_ORI;
            end
            S_ALUWB_I: begin
                bus.reg_write = rst_n;
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.pc_src    = 2'd1;
                bus.pc_en     = bus.zero && rst_n;
                w_cls         = CLS_SUB;
            end
            S_JUMP: begin
                bus.pc_src = 2'd2;
                bus.pc_en  = rst_n;
            end
            S_ERR: begin
                bus.err = 1'b1;
            end
            default: begin
                w_cls = CLS_NONE;
            end
        endcase
    end

    assign bus.alu_cont = w_alu_cont;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam int T = 4;

    typedef struct packed {
        logic       mem_rd;
        logic       mem_wr;
        logic       iord;
        logic       ir_write;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [3:0] alu_cont;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       err;
    } ctl_t;

    typedef struct {
        logic rdy;
        logic rstn;
        ctl_t exp;
    } cyc_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         lat;
        int         rw;
        int         pe;
        logic       er;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.MEM_TIMEOUT(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   total = 0;
    int   bad   = 0;
    cyc_t q[$];
    logic [5:0] cur_op, cur_fn;
    logic cur_z;
    int   obs_lat, obs_rw, obs_pe, obs_rdio;
    logic obs_err, seen_err;
    vec_t vt[11];

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic rdy, input logic rstn, input ctl_t e);
        cyc_t c;
        c.rdy  = rdy;
        c.rstn = rstn;
        c.exp  = e;
        q.push_back(c);
    endtask

    task automatic check_ctl(input string name, input ctl_t exp);
        ctl_t act;
        act = {bus.mem_rd, bus.mem_wr, bus.iord, bus.ir_write, bus.pc_en, bus.pc_src,
               bus.alu_src_a, bus.alu_src_b, bus.ext_zero, bus.alu_cont, bus.reg_dst,
               bus.mem_to_reg, bus.reg_write, bus.err};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: outputs got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Drain the expectation queue one clock per record, observing the DUT mid-cycle
    task automatic play(input string name);
        cyc_t c;
        int   n;
        n = 0;
        obs_lat = 0; obs_rw = 0; obs_pe = 0; obs_rdio = 0;
        obs_err = 1'b0; seen_err = 1'b0;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge clk);
            bus.mem_ready = c.rdy;
            rst_n         = c.rstn;
            bus.opcode    = cur_op;
            bus.funct     = cur_fn;
            bus.zero      = cur_z;
            #1;
            check_ctl($sformatf("%s op=%h fn=%h cyc%0d", name, cur_op, cur_fn, n), c.exp);
            if (!seen_err && !bus.err) obs_lat++;
            if (bus.err) seen_err = 1'b1;
            if (bus.err) obs_err = 1'b1;
            if (bus.reg_write) obs_rw++;
            if (bus.pc_en) obs_pe++;
            if (bus.mem_rd && bus.iord) obs_rdio++;
            n++;
        end
    endtask

    // Sticky error for two cycles, reset for one edge, then one idle cycle before fetch
    task automatic err_tail();
        ctl_t e;
        e = '0;
        e.err = 1'b1;
        push(rbit(), 1'b1, e);
        push(rbit(), 1'b0, e);
        push(rbit(), 1'b1, '0);
    endtask

    // A memory access that sees d not-ready cycles before mem_ready
    task automatic mem_phase(input int kind, input int d, output logic failed);
        ctl_t b;
        int   nw;
        b = '0;
        if (kind == 0) begin
            b.mem_rd    = 1'b1;
            b.alu_src_b = 2'd1;
            b.alu_cont  = ALU_CONTROL_ADDU;
        end else if (kind == 1) begin
            b.mem_rd = 1'b1;
            b.iord   = 1'b1;
        end else begin
            b.mem_wr = 1'b1;
            b.iord   = 1'b1;
        end
        nw = (d >= T) ? T : d;
        for (int i = 0; i < nw; i++) push(1'b0, 1'b1, b);
        if (d >= T) begin
            failed = 1'b1;
        end else begin
            if (kind == 0) begin
                b.ir_write = 1'b1;
                b.pc_en    = 1'b1;
            end
            push(1'b1, 1'b1, b);
            failed = 1'b0;
        end
    endtask

    // Expected cycle-by-cycle trace of one instruction from the instruction table
    task automatic gen_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int df, input int dm);
        ctl_t e;
        logic f;
        logic legal;
        cur_op = op; cur_fn = fn; cur_z = z;
        mem_phase(0, df, f);
        if (f) begin err_tail(); return; end
        e = '0; e.alu_src_b = 2'd3; e.alu_cont = ALU_CONTROL_ADDU;
        push(rbit(), 1'b1, e);
        case (op)
            6'h00:                             legal = fn inside {6'h20, 6'h21, 6'h23};
            6'h23, 6'h2b, 6'h0d, 6'h04, 6'h02: legal = 1'b1;
            default:                           legal = 1'b0;
        endcase
        if (!legal) begin err_tail(); return; end
        e = '0;
        case (op)
            6'h23, 6'h2b: begin
                e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_cont = ALU_CONTROL_ADDU;
                push(rbit(), 1'b1, e);
                mem_phase((op == 6'h23) ? 1 : 2, dm, f);
                if (f) begin err_tail(); return; end
                if (op == 6'h23) begin
                    e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
                    push(rbit(), 1'b1, e);
                end
            end
            6'h00: begin
                e.alu_src_a = 1'b1;
                e.alu_cont  = (fn == 6'h20) ? ALU_CONTROL_ADD :
                              (fn == 6'h21) ? ALU_CONTROL_ADDU : ALU_CONTROL_SUBU;
                push(rbit(), 1'b1, e);
                e = '0; e.reg_write = 1'b1; e.reg_dst = 1'b1;
                push(rbit(), 1'b1, e);
            end
            6'h0d: begin
                e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.ext_zero = 1'b1;
                e.alu_cont  = ALU_CONTROL_ORI;
                push(rbit(), 1'b1, e);
                e = '0; e.reg_write = 1'b1;
                push(rbit(), 1'b1, e);
            end
            6'h04: begin
                e.alu_src_a = 1'b1; e.alu_cont = ALU_CONTROL_SUBU;
                e.pc_src = 2'd1; e.pc_en = z;
                push(rbit(), 1'b1, e);
            end
            default: begin
                e.pc_src = 2'd2; e.pc_en = 1'b1;
                push(rbit(), 1'b1, e);
            end
        endcase
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        ctl_t e;
        logic f;
        logic [5:0] rop, rfn;
        int   k;

        vt[0]  = '{6'h00, 6'h21, 1'b0, 4, 1, 1, 1'b0};
        vt[1]  = '{6'h00, 6'h20, 1'b0, 4, 1, 1, 1'b0};
        vt[2]  = '{6'h00, 6'h23, 1'b1, 4, 1, 1, 1'b0};
        vt[3]  = '{6'h0d, 6'h3f, 1'b0, 4, 1, 1, 1'b0};
        vt[4]  = '{6'h23, 6'h00, 1'b0, 5, 1, 1, 1'b0};
        vt[5]  = '{6'h2b, 6'h00, 1'b1, 4, 0, 1, 1'b0};
        vt[6]  = '{6'h04, 6'h00, 1'b1, 3, 0, 2, 1'b0};
        vt[7]  = '{6'h04, 6'h00, 1'b0, 3, 0, 1, 1'b0};
        vt[8]  = '{6'h02, 6'h11, 1'b0, 3, 0, 2, 1'b0};
        vt[9]  = '{6'h3f, 6'h00, 1'b0, 2, 0, 1, 1'b1};
        vt[10] = '{6'h00, 6'h2a, 1'b0, 2, 0, 1, 1'b1};

        rst_n = 1'b0;
        bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_ctl("reset_state", '0);

        cur_op = '0; cur_fn = '0; cur_z = 1'b0;
        push(rbit(), 1'b1, '0);
        play("reset_exit");

        for (int i = 0; i < 11; i++) begin
            gen_instr(vt[i].op, vt[i].fn, vt[i].z, 0, 0);
            play("vec");
            check_int($sformatf("vec%0d latency", i), obs_lat, vt[i].lat);
            check_int($sformatf("vec%0d reg_write count", i), obs_rw, vt[i].rw);
            check_int($sformatf("vec%0d pc_en count", i), obs_pe, vt[i].pe);
            check_int($sformatf("vec%0d err", i), int'(obs_err), int'(vt[i].er));
        end

        gen_instr(OP_LW, 6'h00, 1'b0, 0, 3);
        play("lw_wait3");
        check_int("lw_wait3 mem_rd+iord cycles", obs_rdio, 4);
        check_int("lw_wait3 reg_write count", obs_rw, 1);

        gen_instr(OP_RTYPE, FN_ADDU, 1'b0, T - 1, 0);
        play("fetch_ready_at_limit");
        check_int("fetch_ready_at_limit err", int'(obs_err), 0);

        gen_instr(OP_RTYPE, FN_ADDU, 1'b0, T, 0);
        play("fetch_timeout");
        check_int("fetch_timeout err", int'(obs_err), 1);
        check_int("fetch_timeout wait cycles", obs_lat, T);

        gen_instr(OP_SW, 6'h00, 1'b0, 0, T);
        play("memwr_timeout");
        check_int("memwr_timeout err", int'(obs_err), 1);

        cur_op = OP_SW; cur_fn = '0; cur_z = 1'b0;
        mem_phase(0, 0, f);
        e = '0; e.alu_src_b = 2'd3; e.alu_cont = ALU_CONTROL_ADDU;
        push(1'b0, 1'b1, e);
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_cont = ALU_CONTROL_ADDU;
        push(1'b0, 1'b1, e);
        e = '0; e.mem_wr = 1'b1; e.iord = 1'b1;
        push(1'b0, 1'b0, e);
        push(1'b0, 1'b1, '0);
        play("reset_in_memwr");

        e = '0; e.mem_rd = 1'b1; e.alu_src_b = 2'd1; e.alu_cont = ALU_CONTROL_ADDU;
        push(1'b1, 1'b0, e);
        push(1'b1, 1'b1, '0);
        play("reset_in_fetch");
        check_int("reset_in_fetch pc_en count", obs_pe, 0);

        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 9);
            case (k)
                0, 1, 2: rop = 6'h00;
                3:       rop = 6'h0d;
                4:       rop = 6'h23;
                5:       rop = 6'h2b;
                6:       rop = 6'h04;
                7:       rop = 6'h02;
                default: rop = 6'($urandom_range(0, 63));
            endcase
            case ($urandom_range(0, 4))
                0:       rfn = 6'($urandom_range(0, 63));
                1:       rfn = 6'h20;
                2:       rfn = 6'h21;
                default: rfn = 6'h23;
            endcase
            gen_instr(rop, rfn, rbit(),
                      ($urandom_range(0, 6) == 0) ? $urandom_range(0, 5) : $urandom_range(0, 2),
                      ($urandom_range(0, 6) == 0) ? $urandom_range(0, 5) : $urandom_range(0, 2));
            play("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
